// File: rtl/rfphoenix_ic_hitmiss_pkg.sv
// ============================================================================
// Module   : rfphoenix_ic_hitmiss_pkg
// Brief    : Shared constants, FSM encoding and helpers for the I$ hit/miss unit
// Revision : 1.0
// ============================================================================
`default_nettype none

package rfphoenix_ic_hitmiss_pkg;

    localparam int ICLINE_BYTES = 64;
    localparam int ICBEATS      = 4;
    localparam int LINE_OFS     = $clog2(ICLINE_BYTES);

    typedef enum logic [1:0] {
        IC_IDLE = 2'd0,
        IC_REQ  = 2'd1,
        IC_FILL = 2'd2,
        IC_TAGW = 2'd3
    } ic_state_t;

    // Lowest set bit wins; returns 0 when nothing matches.
    function automatic logic [1:0] lowest_way(input logic [3:0] match);
        logic [1:0] way;
        way = 2'd0;
        if (match[0])      way = 2'd0;
        else if (match[1]) way = 2'd1;
        else if (match[2]) way = 2'd2;
        else if (match[3]) way = 2'd3;
        return way;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rfphoenix_ic_valid.sv
// ============================================================================
// Module   : rfphoenix_ic_valid
// Brief    : Flop-based per-way line valid bits with set, clear and clear-all
// Revision : 1.0
// ============================================================================
`default_nettype none

module rfphoenix_ic_valid #(
    parameter int WAYS  = 4,
    parameter int LINES = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr_all,
    input  logic                       clr,
    input  logic [1:0]                 clr_way,
    input  logic [$clog2(LINES)-1:0]   clr_idx,
    input  logic                       set,
    input  logic [1:0]                 set_way,
    input  logic [$clog2(LINES)-1:0]   set_idx,
    input  logic [$clog2(LINES)-1:0]   rd_idx,
    output logic [WAYS-1:0]            rd_valid
);

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_way
            logic [LINES-1:0] r_line_v;

            // Clear-all dominates any single-line update in the same cycle.
            always_ff @(posedge clk) begin
                if (rst || clr_all) begin
                    r_line_v <= '0;
                end else begin
                    if (clr && (clr_way == 2'(w)))
                        r_line_v[clr_idx] <= 1'b0;
                    if (set && (set_way == 2'(w)))
                        r_line_v[set_idx] <= 1'b1;
                end
            end

            assign rd_valid[w] = r_line_v[rd_idx];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/rfphoenix_ic_hitmiss.sv
// ============================================================================
// Module   : rfphoenix_ic_hitmiss
// Brief    : 4-way I$ tag compare, miss line fill and tag write-back control
// Revision : 1.0
// ============================================================================
`default_nettype none

module rfphoenix_ic_hitmiss
    import rfphoenix_ic_hitmiss_pkg::*;
#(
    parameter int AWID  = 32,
    parameter int LINES = 128,
    parameter int WAYS  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [AWID-1:0]                      ip,
    input  logic                                 ip_v,
    input  logic [WAYS-1:0][AWID-LINE_OFS-1:0]   tag,
    input  logic                                 inv_all,
    output logic                                 hit,
    output logic [1:0]                           hit_way,
    output logic                                 miss,
    output logic                                 busy,
    output logic                                 req,
    output logic [AWID-1:0]                      req_adr,
    input  logic                                 req_ack,
    input  logic                                 resp_v,
    input  logic [127:0]                         resp_dat,
    input  logic                                 resp_err,
    output logic                                 dat_wr,
    output logic [1:0]                           dat_way,
    output logic [$clog2(LINES)+1:0]             dat_adr,
    output logic [127:0]                         dat_dat,
    output logic                                 tag_wr,
    output logic [1:0]                           tag_way,
    output logic [AWID-1:0]                      tag_ipo,
    output logic                                 fill_err
);

    localparam int TAG_W = AWID - LINE_OFS;
    localparam int IDXW  = $clog2(LINES);

    ic_state_t          r_state;
    ic_state_t          w_state_nxt;
    logic [TAG_W-1:0]   r_rip_line;
    logic               r_rv;
    logic [TAG_W-1:0]   r_fill_line;
    logic [1:0]         r_victim;
    logic [1:0]         r_rr_way;
    logic [1:0]         r_beat;
    logic               r_skip;
    logic               r_inv_pend;

    logic [WAYS-1:0]    w_way_valid;
    logic [WAYS-1:0]    w_match;
    logic [IDXW-1:0]    w_rip_idx;
    logic [IDXW-1:0]    w_fill_idx;
    logic               w_lookup;
    logic               w_set;

    assign w_rip_idx  = r_rip_line[IDXW-1:0];
    assign w_fill_idx = r_fill_line[IDXW-1:0];

    genvar w;
    generate
        for (w = 0; w < WAYS; w++) begin : g_match
            assign w_match[w] = w_way_valid[w] & (tag[w] == r_rip_line);
        end
    endgenerate

    // The cycle after TAGW the tag array still returns the pre-write tag.
    assign w_lookup = r_rv & (r_state == IC_IDLE) & ~r_skip;
    assign hit      = w_lookup & (|w_match);
    assign miss     = w_lookup & ~(|w_match);
    assign hit_way  = hit ? lowest_way(4'(w_match)) : 2'd0;

    assign busy     = (r_state != IC_IDLE);
    assign req_adr  = {r_fill_line, {LINE_OFS{1'b0}}};
    assign dat_way  = r_victim;
    assign dat_adr  = {w_fill_idx, r_beat};
    assign dat_dat  = resp_dat;
    assign tag_way  = r_victim;
    assign tag_ipo  = {r_fill_line, {LINE_OFS{1'b0}}};
    assign w_set    = (r_state == IC_TAGW) & ~r_inv_pend & ~inv_all;

    always_comb begin
        w_state_nxt = r_state;
        req         = 1'b0;
        dat_wr      = 1'b0;
        tag_wr      = 1'b0;
        fill_err    = 1'b0;
        case (r_state)
            IC_IDLE: begin
                if (miss)
                    w_state_nxt = IC_REQ;
            end
            IC_REQ: begin
                req = 1'b1;
                if (req_ack)
                    w_state_nxt = IC_FILL;
            end
            IC_FILL: begin
                if (resp_v) begin
                    if (resp_err) begin
                        fill_err    = 1'b1;
                        w_state_nxt = IC_IDLE;
                    end else begin
                        dat_wr = 1'b1;
                        if (r_beat == 2'(ICBEATS - 1))
                            w_state_nxt = IC_TAGW;
                    end
                end
            end
            IC_TAGW: begin
                tag_wr      = 1'b1;
                w_state_nxt = IC_IDLE;
            end
            default: w_state_nxt = IC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IC_IDLE;
            r_rip_line  <= '0;
            r_rv        <= 1'b0;
            r_fill_line <= '0;
            r_victim    <= 2'd0;
            r_rr_way    <= 2'd0;
            r_beat      <= 2'd0;
            r_skip      <= 1'b0;
            r_inv_pend  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rip_line <= ip[AWID-1:LINE_OFS];
            r_rv       <= ip_v;
            r_skip     <= (r_state == IC_TAGW);
            if (r_state == IC_IDLE && miss) begin
                r_fill_line <= r_rip_line;
                r_victim    <= r_rr_way;
                r_inv_pend  <= 1'b0;
            end
            if (inv_all && r_state != IC_IDLE)
                r_inv_pend <= 1'b1;
            if (r_state == IC_REQ && req_ack)
                r_beat <= 2'd0;
            if (dat_wr)
                r_beat <= r_beat + 2'd1;
            if (r_state == IC_TAGW)
                r_rr_way <= r_rr_way + 2'd1;
        end
    end

    rfphoenix_ic_valid #(
        .WAYS  (WAYS),
        .LINES (LINES)
    ) u_valid (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (inv_all),
        .clr      ((r_state == IC_IDLE) & miss),
        .clr_way  (r_rr_way),
        .clr_idx  (w_rip_idx),
        .set      (w_set),
        .set_way  (r_victim),
        .set_idx  (w_fill_idx),
        .rd_idx   (w_rip_idx),
        .rd_valid (w_way_valid)
    );

endmodule

`default_nettype wire

// File: tb/tb_rfphoenix_ic_hitmiss.sv
// ============================================================================
// Module   : tb_rfphoenix_ic_hitmiss
// Brief    : Directed self-checking bench with a behavioural tag array model
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rfphoenix_ic_hitmiss;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        ip;
    logic               ip_v;
    logic [3:0][25:0]   tag_q;
    logic               inv_all;
    logic               hit;
    logic [1:0]         hit_way;
    logic               miss;
    logic               busy;
    logic               req;
    logic [31:0]        req_adr;
    logic               req_ack;
    logic               resp_v;
    logic [127:0]       resp_dat;
    logic               resp_err;
    logic               dat_wr;
    logic [1:0]         dat_way;
    logic [8:0]         dat_adr;
    logic [127:0]       dat_dat;
    logic               tag_wr;
    logic [1:0]         tag_way;
    logic [31:0]        tag_ipo;
    logic               fill_err;

    int n_checks = 0;
    int n_errors = 0;

    logic [25:0] tag_mem [4][128];

    always #5 clk = ~clk;

    rfphoenix_ic_hitmiss dut (
        .clk      (clk),
        .rst      (rst),
        .ip       (ip),
        .ip_v     (ip_v),
        .tag      (tag_q),
        .inv_all  (inv_all),
        .hit      (hit),
        .hit_way  (hit_way),
        .miss     (miss),
        .busy     (busy),
        .req      (req),
        .req_adr  (req_adr),
        .req_ack  (req_ack),
        .resp_v   (resp_v),
        .resp_dat (resp_dat),
        .resp_err (resp_err),
        .dat_wr   (dat_wr),
        .dat_way  (dat_way),
        .dat_adr  (dat_adr),
        .dat_dat  (dat_dat),
        .tag_wr   (tag_wr),
        .tag_way  (tag_way),
        .tag_ipo  (tag_ipo),
        .fill_err (fill_err)
    );

    // Tag array: registered read of ip, write on tag_wr, no write-to-read bypass.
    always @(posedge clk) begin
        for (int w = 0; w < 4; w++)
            tag_q[w] <= tag_mem[w][ip[12:6]];
        if (tag_wr)
            tag_mem[tag_way][tag_ipo[12:6]] <= tag_ipo[31:6];
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] a);
        ip   = a;
        ip_v = 1'b1;
        tick();
    endtask

    // Entered in the cycle where the miss for 'a' is visible.
    task automatic fill_line(input logic [31:0] a, input logic [1:0] v,
                             input int err_beat, input bit inv_b1);
        check("miss_seen", miss, 1);
        check("hit_on_miss", hit, 0);
        tick();
        check("req", req, 1);
        check("req_adr", req_adr, {a[31:6], 6'h0});
        check("busy_req", busy, 1);
        resp_v = 1'b1;
        #1;
        check("resp_in_req", dat_wr, 0);
        tick();
        resp_v = 1'b0;
        check("req_hold", req, 1);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        for (int b = 0; b < 4; b++) begin
            resp_v   = 1'b1;
            resp_dat = 128'(a) + 128'(b);
            resp_err = (b == err_beat);
            inv_all  = inv_b1 && (b == 1);
            #1;
            if (b == err_beat) begin
                check("fill_err", fill_err, 1);
                check("dat_wr_err", dat_wr, 0);
                tick();
                resp_v   = 1'b0;
                resp_err = 1'b0;
                #1;
                check("busy_after_err", busy, 0);
                check("tag_wr_after_err", tag_wr, 0);
                check("fill_err_pulse", fill_err, 0);
                return;
            end
            check("dat_wr", dat_wr, 1);
            check("dat_adr", dat_adr, {a[12:6], 2'(b)});
            check("dat_way", dat_way, v);
            check("dat_dat", dat_dat, 128'(a) + 128'(b));
            tick();
        end
        resp_v  = 1'b0;
        inv_all = 1'b0;
        #1;
        check("tag_wr", tag_wr, 1);
        check("tag_way", tag_way, v);
        check("tag_ipo", tag_ipo, {a[31:6], 6'h0});
        tick();
        check("skip_hit", hit, 0);
        check("skip_miss", miss, 0);
        check("skip_busy", busy, 0);
        check("skip_tag_wr", tag_wr, 0);
    endtask

    logic [31:0] fill_seq [4];
    logic [1:0]  fill_way [4];
    logic [31:0] hit_seq  [8];
    logic [1:0]  hit_exp  [8];

    initial begin
        for (int w = 0; w < 4; w++)
            for (int l = 0; l < 128; l++)
                tag_mem[w][l] = '1;
        fill_seq = '{32'h0000_3040, 32'h0000_5040, 32'h0000_7040, 32'h0000_9040};
        fill_way = '{2'd1, 2'd2, 2'd3, 2'd0};
        hit_seq  = '{32'h3040, 32'h5040, 32'h7040, 32'h9040,
                     32'h9040, 32'h7040, 32'h5040, 32'h3040};
        hit_exp  = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd3, 2'd2, 2'd1};

        rst = 1'b1; ip = '0; ip_v = 1'b0; inv_all = 1'b0;
        req_ack = 1'b0; resp_v = 1'b0; resp_dat = '0; resp_err = 1'b0;
        repeat (3) tick();
        check("rst_req", req, 0);
        check("rst_busy", busy, 0);
        check("rst_dat_wr", dat_wr, 0);
        check("rst_tag_wr", tag_wr, 0);
        check("rst_fill_err", fill_err, 0);
        check("rst_hit", hit, 0);
        check("rst_miss", miss, 0);
        rst = 1'b0;
        tick();
        check("idle_hit", hit, 0);
        check("idle_miss", miss, 0);

        // Power-up tag of all ones matches this address but valid is clear.
        present(32'hFFFF_FFC0);
        check("pwrup_tag_hit", hit, 0);
        check("pwrup_tag_miss", miss, 1);
        rst = 1'b1; ip_v = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("pwrup_busy", busy, 0);

        // Cold miss to way 0, then re-fetch hits.
        present(32'h0000_1040);
        check("cold_req_adr_pre", busy, 0);
        fill_line(32'h0000_1040, 2'd0, -1, 1'b0);
        tick();
        check("cold_hit", hit, 1);
        check("cold_hit_way", hit_way, 2'd0);

        // Same-index fills rotate through ways 1,2,3 then evict way 0.
        for (int i = 0; i < 4; i++) begin
            present(fill_seq[i]);
            fill_line(fill_seq[i], fill_way[i], -1, 1'b0);
            tick();
            check("rr_hit", hit, 1);
            check("rr_hit_way", hit_way, fill_way[i]);
        end

        // Back-to-back hits, one new address per cycle.
        for (int i = 0; i < 8; i++) begin
            present(hit_seq[i]);
            check("b2b_hit", hit, 1);
            check("b2b_way", hit_way, hit_exp[i]);
            check("b2b_busy", busy, 0);
            check("b2b_req", req, 0);
        end

        // Evicted line misses; bus error on beat 2 aborts the fill.
        present(32'h0000_1040);
        fill_line(32'h0000_1040, 2'd1, 2, 1'b0);
        check("miss_after_err", miss, 1);

        // Invalidate during the fill: it completes but the line stays invalid.
        fill_line(32'h0000_1040, 2'd1, -1, 1'b1);
        tick();
        check("inv_line_miss", miss, 1);
        check("inv_line_hit", hit, 0);
        fill_line(32'h0000_1040, 2'd2, -1, 1'b0);
        tick();
        check("refill_hit", hit, 1);
        check("refill_way", hit_way, 2'd2);
        present(32'h0000_7040);
        check("inv_other_miss", miss, 1);
        check("inv_other_hit", hit, 0);

        // Reset while on FILL beat 1; a late beat must not write.
        tick();
        check("rstfill_req", req, 1);
        req_ack = 1'b1;
        tick();
        req_ack = 1'b0;
        resp_v = 1'b1;
        resp_dat = 128'h1234;
        tick();
        check("rstfill_beat1", dat_adr, 9'h105);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rstfill_busy", busy, 0);
        check("rstfill_req0", req, 0);
        check("rstfill_late", dat_wr, 0);
        check("rstfill_tag_wr", tag_wr, 0);
        tick();
        check("rstfill_miss", miss, 1);
        check("rstfill_hit", hit, 0);
        check("rstfill_late2", dat_wr, 0);
        resp_v = 1'b0;
        ip_v   = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
